// File: rtl/dispatch_2way_buffer_if.sv
// Handshake and payload bundle for dispatch_2way_buffer.
//   slave  : the buffer's view. It receives the producer stream and the consumer
//            ready bits, and drives ready, route, both output heads and the counts.
//   master : the environment's view, with every direction reversed.
// Signals:
//   flush_i          synchronous clear of both FIFOs
//   valid_i/ready_o  producer handshake; data_i is the payload
//   dest_i, any_i    explicit destination, or "first port with space" mode
//   route_o          port the current input word is steered to
//   valid_o/ready_i  per-port consumer handshake (bit k = port k)
//   data0_o/data1_o  FIFO head words
//   cnt0_o/cnt1_o    FIFO occupancies
interface dispatch_2way_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic              dest_i;
    logic              any_i;
    logic              route_o;
    logic [1:0]        valid_o;
    logic [1:0]        ready_i;
    logic [DATA_W-1:0] data0_o;
    logic [DATA_W-1:0] data1_o;
    logic [CW-1:0]     cnt0_o;
    logic [CW-1:0]     cnt1_o;

    modport slave (
        input  flush_i, valid_i, data_i, dest_i, any_i, ready_i,
        output ready_o, route_o, valid_o, data0_o, data1_o, cnt0_o, cnt1_o
    );

    modport master (
        output flush_i, valid_i, data_i, dest_i, any_i, ready_i,
        input  ready_o, route_o, valid_o, data0_o, data1_o, cnt0_o, cnt1_o
    );
endinterface

// File: rtl/dispatch_2way_buffer.sv
// dispatch_2way_buffer: steers one valid/ready stream into two independent
// output FIFOs. A word goes either to dest_i or, in "any" mode, to FIFO 0
// unless that FIFO is full, in which case it goes to FIFO 1.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset; clears pointers, counts and storage
//   bus    dispatch_2way_buffer_if.slave (see the interface file for the signal list)
// ready_o is a function of registered occupancy, any_i, dest_i, flush_i and
// rst_i only, so there is no combinational path from valid_i or ready_i to it.
// A full FIFO therefore does not accept a word in the same cycle it pops one.
module dispatch_2way_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    dispatch_2way_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_r    [2][DEPTH];
    logic [AW-1:0]     wr_ptr_r [2];
    logic [AW-1:0]     rd_ptr_r [2];
    logic [CW-1:0]     cnt_r    [2];

    logic [1:0] full_s;
    logic [1:0] empty_s;
    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic       route_s;
    logic       ready_s;

    // Routing, input ready and the per-FIFO push/pop strobes.
    always_comb begin
        full_s   = 2'b00;
        empty_s  = 2'b00;
        route_s  = 1'b0;
        ready_s  = 1'b0;
        push_s   = 2'b00;
        pop_s    = 2'b00;

        full_s[0]  = (cnt_r[0] == CW'(DEPTH));
        full_s[1]  = (cnt_r[1] == CW'(DEPTH));
        empty_s[0] = (cnt_r[0] == {CW{1'b0}});
        empty_s[1] = (cnt_r[1] == {CW{1'b0}});

        if (bus.any_i) begin
            route_s = full_s[0];
        end else begin
            route_s = bus.dest_i;
        end

        // Reset and flush both close the input so nothing lands in a FIFO being cleared.
        if (rst_i || bus.flush_i) begin
            ready_s = 1'b0;
        end else if (bus.any_i) begin
            ready_s = !(full_s[0] && full_s[1]);
        end else begin
            ready_s = !full_s[bus.dest_i];
        end

        push_s[0] = bus.valid_i & ready_s & ~route_s;
        push_s[1] = bus.valid_i & ready_s &  route_s;
        pop_s     = ~empty_s & bus.ready_i;
    end

    // FIFO storage, pointers and occupancy counts for both ports.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_r[k] <= {AW{1'b0}};
                rd_ptr_r[k] <= {AW{1'b0}};
                cnt_r[k]    <= {CW{1'b0}};
                for (int e = 0; e < DEPTH; e++) begin
                    mem_r[k][e] <= {DATA_W{1'b0}};
                end
            end
        end else if (bus.flush_i) begin
            // Storage is left as-is; with zero counts the stale words are unreachable.
            for (int k = 0; k < 2; k++) begin
                wr_ptr_r[k] <= {AW{1'b0}};
                rd_ptr_r[k] <= {AW{1'b0}};
                cnt_r[k]    <= {CW{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push_s[k]) begin
                    mem_r[k][wr_ptr_r[k]] <= bus.data_i;
                    wr_ptr_r[k]           <= wr_ptr_r[k] + AW'(1);
                end else begin
                    wr_ptr_r[k] <= wr_ptr_r[k];
                end
                if (pop_s[k]) begin
                    rd_ptr_r[k] <= rd_ptr_r[k] + AW'(1);
                end else begin
                    rd_ptr_r[k] <= rd_ptr_r[k];
                end
                case ({push_s[k], pop_s[k]})
                    2'b10:   cnt_r[k] <= cnt_r[k] + CW'(1);
                    2'b01:   cnt_r[k] <= cnt_r[k] - CW'(1);
                    default: cnt_r[k] <= cnt_r[k];
                endcase
            end
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.route_o = route_s;
    assign bus.valid_o = ~empty_s;
    assign bus.data0_o = mem_r[0][rd_ptr_r[0]];
    assign bus.data1_o = mem_r[1][rd_ptr_r[1]];
    assign bus.cnt0_o  = cnt_r[0];
    assign bus.cnt1_o  = cnt_r[1];
endmodule

// File: tb/tb_dispatch_2way_buffer.sv
// Directed self-checking bench for dispatch_2way_buffer (DATA_W=32, DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_dispatch_2way_buffer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    dispatch_2way_buffer_if #(.DATA_W(32), .DEPTH(2)) bus ();

    dispatch_2way_buffer #(.DATA_W(32), .DEPTH(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // A stalled word must stay presented until accepted (flush discards it).
    property p_valid_hold;
        @(posedge clk_i) disable iff (rst_i)
            (bus.valid_i && !bus.ready_o && !bus.flush_i) |=> bus.valid_i;
    endproperty
    a_valid_hold: assert property (p_valid_hold)
        else $error("input contract: valid_i dropped before handshake");

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic dst,
                         input logic any, input logic [1:0] rdy);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.dest_i  = dst;
        bus.any_i   = any;
        bus.ready_i = rdy;
    endtask

    initial begin
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);

        // ---- reset and idle ----
        cyc();
        settle();
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_cnt0", 32'(bus.cnt0_o), 32'd0);
        check("rst_cnt1", 32'(bus.cnt1_o), 32'd0);
        check("rst_data0", bus.data0_o, 32'h0);
        check("rst_data1", bus.data1_o, 32'h0);
        cyc();
        rst_i = 1'b0;
        settle();
        check("rel_ready", 32'(bus.ready_o), 32'd1);
        check("rel_route_d0", 32'(bus.route_o), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        settle();
        check("rel_route_d1", 32'(bus.route_o), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        settle();
        check("rel_route_any", 32'(bus.route_o), 32'd0);

        // ---- directed fill of port 1 ----
        cyc();
        drive(1'b1, 32'hA1, 1'b1, 1'b0, 2'b00);
        settle();
        check("fill_rdy1", 32'(bus.ready_o), 32'd1);
        check("fill_route", 32'(bus.route_o), 32'd1);
        cyc();
        drive(1'b1, 32'hA2, 1'b1, 1'b0, 2'b00);
        settle();
        check("fill_rdy2", 32'(bus.ready_o), 32'd1);
        check("fill_lat", 32'(bus.valid_o), 32'b10);
        cyc();
        // third word stalls; pop in the same cycle must not open the input
        drive(1'b1, 32'hA3, 1'b1, 1'b0, 2'b10);
        settle();
        check("fill_cnt1", 32'(bus.cnt1_o), 32'd2);
        check("fill_rdy3", 32'(bus.ready_o), 32'd0);
        check("fill_valid", 32'(bus.valid_o), 32'b10);
        check("fill_head1", bus.data1_o, 32'hA1);
        check("fill_cnt0", 32'(bus.cnt0_o), 32'd0);
        cyc();
        settle();
        check("fill_pop_cnt", 32'(bus.cnt1_o), 32'd1);
        check("fill_pop_head", bus.data1_o, 32'hA2);
        check("fill_pop_rdy", 32'(bus.ready_o), 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 2'b10);
        settle();
        check("fill_pushpop_cnt", 32'(bus.cnt1_o), 32'd1);
        check("fill_head3", bus.data1_o, 32'hA3);
        cyc();
        settle();
        check("fill_empty", 32'(bus.valid_o), 32'b00);
        check("fill_cnt1_0", 32'(bus.cnt1_o), 32'd0);

        // ---- any-mode overflow (dest_i=1 must be ignored) ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 1'b1, 1'b1, 2'b00);
            settle();
            check("any_rdy", 32'(bus.ready_o), 32'd1);
            check("any_route", 32'(bus.route_o), (i < 2) ? 32'd0 : 32'd1);
            cyc();
        end
        drive(1'b1, 32'h14, 1'b1, 1'b1, 2'b00);
        settle();
        check("any_full_rdy", 32'(bus.ready_o), 32'd0);
        check("any_valid", 32'(bus.valid_o), 32'b11);
        check("any_cnt0", 32'(bus.cnt0_o), 32'd2);
        check("any_cnt1", 32'(bus.cnt1_o), 32'd2);
        check("any_head0", bus.data0_o, 32'h10);
        check("any_head1", bus.data1_o, 32'h12);
        // free one slot in port 0; the held word then goes there
        bus.ready_i = 2'b01;
        settle();
        check("any_pop_rdy", 32'(bus.ready_o), 32'd0);
        cyc();
        bus.ready_i = 2'b00;
        settle();
        check("any_reopen_rdy", 32'(bus.ready_o), 32'd1);
        check("any_reopen_route", 32'(bus.route_o), 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b11);
        settle();
        check("any_refill_cnt0", 32'(bus.cnt0_o), 32'd2);
        check("any_drain_h0a", bus.data0_o, 32'h11);
        check("any_drain_h1a", bus.data1_o, 32'h12);
        cyc();
        settle();
        check("any_drain_h0b", bus.data0_o, 32'h14);
        check("any_drain_h1b", bus.data1_o, 32'h13);
        cyc();
        bus.ready_i = 2'b00;
        settle();
        check("any_drained", 32'(bus.valid_o), 32'b00);

        // ---- full FIFO 0 with simultaneous pop ----
        drive(1'b1, 32'h20, 1'b0, 1'b0, 2'b00);
        cyc();
        drive(1'b1, 32'h21, 1'b0, 1'b0, 2'b00);
        cyc();
        drive(1'b1, 32'h22, 1'b0, 1'b0, 2'b01);
        settle();
        check("fp_rdy", 32'(bus.ready_o), 32'd0);
        check("fp_cnt0", 32'(bus.cnt0_o), 32'd2);
        cyc();
        bus.ready_i = 2'b00;
        settle();
        check("fp_cnt_next", 32'(bus.cnt0_o), 32'd1);
        check("fp_rdy_next", 32'(bus.ready_o), 32'd1);
        check("fp_head", bus.data0_o, 32'h21);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
        settle();
        check("fp_accepted", 32'(bus.cnt0_o), 32'd2);
        cyc();
        settle();
        check("fp_head2", bus.data0_o, 32'h22);
        cyc();
        bus.ready_i = 2'b00;
        settle();
        check("fp_empty", 32'(bus.valid_o), 32'b00);

        // ---- streaming with wrap-around on port 0 ----
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 2'b01);
            settle();
            check("st_rdy", 32'(bus.ready_o), 32'd1);
            check("st_cnt_le1", 32'(bus.cnt0_o <= 2'd1), 32'd1);
            if (i > 0) begin
                check("st_valid", 32'(bus.valid_o), 32'b01);
                check("st_data", bus.data0_o, 32'h30 + 32'(i - 1));
            end else begin
                check("st_first_empty", 32'(bus.valid_o), 32'b00);
            end
            cyc();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
        settle();
        check("st_last", bus.data0_o, 32'h39);
        cyc();
        settle();
        check("st_done", 32'(bus.valid_o), 32'b00);

        // ---- flush ----
        drive(1'b1, 32'h40, 1'b0, 1'b0, 2'b00);
        cyc();
        drive(1'b1, 32'h41, 1'b1, 1'b0, 2'b00);
        cyc();
        settle();
        check("fl_pre_valid", 32'(bus.valid_o), 32'b11);
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h42, 1'b0, 1'b0, 2'b11);
        settle();
        check("fl_rdy", 32'(bus.ready_o), 32'd0);
        cyc();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        settle();
        check("fl_valid", 32'(bus.valid_o), 32'b00);
        check("fl_cnt0", 32'(bus.cnt0_o), 32'd0);
        check("fl_cnt1", 32'(bus.cnt1_o), 32'd0);
        cyc();
        settle();
        check("fl_not_stored", 32'(bus.valid_o), 32'b00);

        // ---- reset mid-stream with two words in FIFO 0 ----
        drive(1'b1, 32'h50, 1'b0, 1'b0, 2'b00);
        cyc();
        drive(1'b1, 32'h51, 1'b0, 1'b0, 2'b00);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        settle();
        check("mr_pre_cnt0", 32'(bus.cnt0_o), 32'd2);
        rst_i = 1'b1;
        settle();
        check("mr_rdy", 32'(bus.ready_o), 32'd0);
        check("mr_valid", 32'(bus.valid_o), 32'b00);
        check("mr_cnt0", 32'(bus.cnt0_o), 32'd0);
        check("mr_data0", bus.data0_o, 32'h0);
        cyc();
        rst_i = 1'b0;
        settle();
        check("mr_rel_rdy", 32'(bus.ready_o), 32'd1);
        check("mr_rel_valid", 32'(bus.valid_o), 32'b00);
        cyc();
        settle();
        check("mr_no_stale", 32'(bus.valid_o), 32'b00);
        check("mr_no_stale_cnt", 32'(bus.cnt0_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
